pool_layer_sequencer: RTL
=========================

Name: pool_layer_sequencer

Overview:
- Layer-level controller sequencing the conv engine and the 2x2 max-pooling stage across all output channels of one LeNet-5 conv layer.
- Per channel: starts conv, waits for conv completion, arms pooling via cal_wait, waits for pool_done, then advances the channel/bank index.
- Sits between the top-level network FSM (start/done) and the conv/pool datapaths. Adds a pooling watchdog and a clean inter-channel gap so the pooling block's internal counters clear.

Parameters:
- NUM_CH, 6, channels per layer (1..15).
- CH_W, 4, width of the channel index.
- GAP_CYCLES, 4, cycles cal_wait is held at 2'b00 between channels (min 2).
- POOL_TIMEOUT, 2047, max cycles in POOL before error; 11-bit watchdog.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous active-high reset
- layer_start  in  1  one-cycle pulse; starts a layer when idle
- layer_busy  out  1  high from accept until layer_done
- layer_done  out  1  one-cycle pulse after the last channel is pooled
- layer_err  out  1  sticky watchdog error; cleared by rst or an accepted layer_start
- conv_start  out  1  one-cycle pulse per channel
- conv_done  in  1  one-cycle pulse from the conv engine
- cal_wait  out  2  to pooling: 2'b11 run, 2'b01 conv active, 2'b00 idle/clear
- pool_done  in  1  level from pooling, high once the channel is written
- ch_idx  out  CH_W  current channel; selects BRAM bank
- pool_bank_we_en  out  1  high only in POOL; gates the pooling BRAM write enable

Behaviour:
- All outputs are registered. Reset values: layer_busy=0, layer_done=0, layer_err=0, conv_start=0, cal_wait=2'b00, ch_idx=0, pool_bank_we_en=0, state=IDLE, counters=0.
- Reset is synchronous and overrides everything, including mid-layer. The next cycle is IDLE with all outputs at reset values.
- IDLE:
  - On layer_start, set ch_idx=0, clear layer_err, set layer_busy=1, go to CONV_KICK.
  - layer_start in any other state is ignored.
- CONV_KICK:
  - Assert conv_start for exactly 1 cycle and set cal_wait=2'b01. Go to CONV_WAIT.
- CONV_WAIT:
  - cal_wait=2'b01. On conv_done, go to POOL; the next cycle shows cal_wait=2'b11.
  - A conv_done seen outside CONV_WAIT is ignored.
- POOL:
  - cal_wait=2'b11, pool_bank_we_en=1, watchdog increments each cycle.
  - pool_done=1 (sampled), next cycle: cal_wait=2'b00, pool_bank_we_en=0, go to GAP.
  - If watchdog==POOL_TIMEOUT before pool_done: set layer_err=1, drop cal_wait to 2'b00, go to GAP. The layer continues with the next channel; there is no abort.
  - If pool_done and timeout occur in the same cycle, pool_done wins and layer_err is not set.
- GAP:
  - cal_wait=2'b00 for exactly GAP_CYCLES cycles; the gap counter starts at 0 on entry.
  - On the final cycle: if ch_idx==NUM_CH-1, go to DONE. Otherwise ch_idx<=ch_idx+1 and go to CONV_KICK.
  - pool_done still high during GAP is ignored.
- DONE:
  - layer_done=1 for one cycle, layer_busy<=0, ch_idx<=0, go to IDLE.
  - layer_start is accepted on the cycle after DONE, not during it.
- Latency:
  - layer_start to conv_start: 2 cycles.
  - conv_done to cal_wait=11: 1 cycle.
  - pool_done to cal_wait=00: 1 cycle.
  - Channel-to-channel overhead after pool_done: 1+GAP_CYCLES+1 cycles.
- ch_idx is stable for the whole CONV_KICK..GAP span of a channel. It never exceeds NUM_CH-1 and never wraps.
- Watchdog is 11 bits, cleared on entry to POOL, saturating.

Test Plan:
- NUM_CH=6, ideal conv_done 100 cycles after each conv_start, pool_done 800 cycles after cal_wait=11 -> 6 conv_start pulses, ch_idx 0..5, each gap exactly 4 cycles of cal_wait=00, one layer_done pulse, layer_err=0.
- Pulse layer_start during CONV_WAIT and again during POOL -> ignored; ch_idx and state sequence unchanged.
- Hold pool_done low on channel 2 -> cal_wait=00 exactly 2048 cycles after POOL entry, layer_err=1 and sticky, channels 3..5 still run, layer_done pulses; next layer_start clears layer_err.
- Assert rst in POOL on channel 3 -> next cycle cal_wait=00, ch_idx=0, layer_busy=0; a new layer_start restarts from channel 0.
- Assert pool_done on the exact cycle the watchdog reaches 2047 -> normal advance, layer_err stays 0.
- Inject a stray conv_done during IDLE and GAP -> no state change, no conv_start.

Source files
------------

// File: rtl/pool_layer_sequencer_if.sv
// Handshake bundle between the layer sequencer, the network FSM and the
// conv/pool datapaths. The sequencer side uses the master modport.
interface pool_layer_sequencer_if #(
  parameter int CH_W = 4
);
  logic            layer_start;
  logic            layer_busy;
  logic            layer_done;
  logic            layer_err;
  logic            conv_start;
  logic            conv_done;
  logic [1:0]      cal_wait;
  logic            pool_done;
  logic [CH_W-1:0] ch_idx;
  logic            pool_bank_we_en;

  modport master (
    input  layer_start,
    input  conv_done,
    input  pool_done,
    output layer_busy,
    output layer_done,
    output layer_err,
    output conv_start,
    output cal_wait,
    output ch_idx,
    output pool_bank_we_en
  );

  modport slave (
    output layer_start,
    output conv_done,
    output pool_done,
    input  layer_busy,
    input  layer_done,
    input  layer_err,
    input  conv_start,
    input  cal_wait,
    input  ch_idx,
    input  pool_bank_we_en
  );
endinterface

// File: rtl/pool_layer_sequencer.sv
// Layer-level sequencer: walks every output channel through conv, 2x2 max
// pooling and an idle gap, with a watchdog on the pooling phase.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for layer_start
// CONV_KICK | one cycle; conv_start is registered out of this state
// CONV_WAIT | conv engine running, waiting for conv_done
// POOL      | pooling running, waiting for pool_done or watchdog expiry
// GAP       | cal_wait held at 00 so the pooling counters clear
// DONE      | one cycle; layer_done visible, busy drops afterwards
//
// Every output is a flop. Most are loaded from next_state so they change on
// the same edge as the state; conv_start is loaded from the current state,
// which places it one cycle after CONV_KICK is entered.
module pool_layer_sequencer #(
  parameter int NUM_CH       = 6,
  parameter int CH_W         = 4,
  parameter int GAP_CYCLES   = 4,
  parameter int POOL_TIMEOUT = 2047
) (
  input  logic                   clk,
  input  logic                   rst,
  pool_layer_sequencer_if.master bus
);

  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONV_KICK,
    S_CONV_WAIT,
    S_POOL,
    S_GAP,
    S_DONE
  } state_t;

  state_t state, next_state;

  logic [10:0]      wd_q, wd_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [CH_W-1:0]  ch_q, ch_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             conv_start_q, conv_start_d;
  logic [1:0]       cal_wait_q, cal_wait_d;
  logic             we_q, we_d;

  logic timeout;
  logic gap_last;
  logic last_ch;

  assign timeout  = (wd_q == 11'(POOL_TIMEOUT));
  assign gap_last = (gap_q == GAP_W'(GAP_CYCLES - 1));
  assign last_ch  = (ch_q == CH_W'(NUM_CH - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // Next-state decode; pool_done is checked before the watchdog so it wins a tie.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:      if (bus.layer_start) next_state = S_CONV_KICK;
      S_CONV_KICK: next_state = S_CONV_WAIT;
      S_CONV_WAIT: if (bus.conv_done) next_state = S_POOL;
      S_POOL:      if (bus.pool_done || timeout) next_state = S_GAP;
      S_GAP:       if (gap_last) next_state = last_ch ? S_DONE : S_CONV_KICK;
      S_DONE:      next_state = S_IDLE;
      default:     next_state = S_IDLE;
    endcase
  end

  // Next values for the registered outputs and the two counters.
  always_comb begin
    busy_d       = busy_q;
    err_d        = err_q;
    ch_d         = ch_q;
    done_d       = (next_state == S_DONE);
    conv_start_d = (state == S_CONV_KICK);
    we_d         = (next_state == S_POOL);
    wd_d         = '0;
    gap_d        = '0;

    case (next_state)
      S_CONV_KICK, S_CONV_WAIT: cal_wait_d = 2'b01;
      S_POOL:                   cal_wait_d = 2'b11;
      default:                  cal_wait_d = 2'b00;
    endcase

    if (state == S_IDLE && bus.layer_start) begin
      busy_d = 1'b1;
      err_d  = 1'b0;
      ch_d   = '0;
    end

    if (state == S_POOL && !bus.pool_done && timeout) err_d = 1'b1;

    if (state == S_POOL && next_state == S_POOL)
      wd_d = (wd_q == 11'h7FF) ? wd_q : wd_q + 11'd1;

    if (state == S_GAP && next_state == S_GAP) gap_d = gap_q + GAP_W'(1);

    if (state == S_GAP && gap_last && !last_ch) ch_d = ch_q + CH_W'(1);

    if (state == S_DONE) begin
      busy_d = 1'b0;
      ch_d   = '0;
    end
  end

  // Output and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      conv_start_q <= 1'b0;
      cal_wait_q   <= 2'b00;
      ch_q         <= '0;
      we_q         <= 1'b0;
      wd_q         <= '0;
      gap_q        <= '0;
    end else begin
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      conv_start_q <= conv_start_d;
      cal_wait_q   <= cal_wait_d;
      ch_q         <= ch_d;
      we_q         <= we_d;
      wd_q         <= wd_d;
      gap_q        <= gap_d;
    end
  end

  assign bus.layer_busy      = busy_q;
  assign bus.layer_done      = done_q;
  assign bus.layer_err       = err_q;
  assign bus.conv_start      = conv_start_q;
  assign bus.cal_wait        = cal_wait_q;
  assign bus.ch_idx          = ch_q;
  assign bus.pool_bank_we_en = we_q;

endmodule
